// File: rtl/wb_commit_arbiter.sv
// Writeback commit arbiter: per-pipe result FIFOs feeding a single
// register-file write port, fixed-priority or round-robin selection.
module wb_commit_arbiter #(
   parameter int NUM_PIPES  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int REG_WIDTH  = 5,
   parameter int FIFO_DEPTH = 2,
   parameter int ARB_MODE   = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PIPES-1:0]            in_valid,
   output logic [NUM_PIPES-1:0]            in_ready,
   input  logic [NUM_PIPES-1:0]            in_register_write,
   input  logic [NUM_PIPES*REG_WIDTH-1:0]  in_rd,
   input  logic [NUM_PIPES*DATA_WIDTH-1:0] in_data,
   output logic                            wb_wr_en,
   output logic [REG_WIDTH-1:0]            wb_rd,
   output logic [DATA_WIDTH-1:0]           wb_wr_data,
   output logic [NUM_PIPES-1:0]            wb_grant,
   output logic                            busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

   logic [REG_WIDTH-1:0]  rd_mem_q   [NUM_PIPES][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [NUM_PIPES][FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q [NUM_PIPES];
   logic [PTR_W-1:0] wr_ptr_d [NUM_PIPES];
   logic [PTR_W-1:0] rd_ptr_q [NUM_PIPES];
   logic [PTR_W-1:0] rd_ptr_d [NUM_PIPES];
   logic [CNT_W-1:0] count_q  [NUM_PIPES];
   logic [CNT_W-1:0] count_d  [NUM_PIPES];

   logic [NUM_PIPES-1:0] empty_s;
   logic [NUM_PIPES-1:0] full_s;
   logic [NUM_PIPES-1:0] store_s;
   logic [NUM_PIPES-1:0] pop_s;

   logic             grant_valid_s;
   logic [IDX_W-1:0] win_idx_s;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] rr_ptr_d;

   logic                  wb_wr_en_q,   wb_wr_en_d;
   logic [REG_WIDTH-1:0]  wb_rd_q,      wb_rd_d;
   logic [DATA_WIDTH-1:0] wb_wr_data_q, wb_wr_data_d;
   logic [NUM_PIPES-1:0]  wb_grant_q,   wb_grant_d;

   // FIFO status and push qualification; non-writing results are accepted but never stored
   always_comb begin
      for (int i = 0; i < NUM_PIPES; i++) begin
         empty_s[i] = (count_q[i] == {CNT_W{1'b0}});
         full_s[i]  = (count_q[i] == CNT_W'(FIFO_DEPTH));
         store_s[i] = in_valid[i] & ~full_s[i] & in_register_write[i] &
                      (in_rd[i*REG_WIDTH +: REG_WIDTH] != {REG_WIDTH{1'b0}});
      end
   end

   // Winner selection over non-empty FIFO heads; descending loops let the preferred index overwrite
   always_comb begin
      int rr_idx;
      rr_idx        = 0;
      grant_valid_s = 1'b0;
      win_idx_s     = {IDX_W{1'b0}};
      if (ARB_MODE == 0) begin
         for (int k = NUM_PIPES - 1; k >= 0; k--) begin
            grant_valid_s = grant_valid_s | ~empty_s[k];
            win_idx_s     = empty_s[k] ? win_idx_s : IDX_W'(k);
         end
      end else begin
         for (int k = NUM_PIPES; k >= 1; k--) begin
            rr_idx        = (int'(rr_ptr_q) + k) % NUM_PIPES;
            grant_valid_s = grant_valid_s | ~empty_s[rr_idx];
            win_idx_s     = empty_s[rr_idx] ? win_idx_s : IDX_W'(rr_idx);
         end
      end
   end

   // Pop vector, pointer/count updates and next values of the write-port registers
   always_comb begin
      for (int i = 0; i < NUM_PIPES; i++) begin
         pop_s[i]    = grant_valid_s & (win_idx_s == IDX_W'(i));
         wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(store_s[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop_s[i]);
         count_d[i]  = count_q[i] + CNT_W'(store_s[i]) - CNT_W'(pop_s[i]);
      end
      wb_wr_en_d = grant_valid_s;
      wb_grant_d = pop_s;
      if (grant_valid_s) begin
         wb_rd_d      = rd_mem_q[win_idx_s][rd_ptr_q[win_idx_s]];
         wb_wr_data_d = data_mem_q[win_idx_s][rd_ptr_q[win_idx_s]];
         rr_ptr_d     = win_idx_s;
      end else begin
         wb_rd_d      = wb_rd_q;
         wb_wr_data_d = wb_wr_data_q;
         rr_ptr_d     = rr_ptr_q;
      end
   end

   // State registers with synchronous reset; reset drops every buffered and in-flight entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            wr_ptr_q[i] <= {PTR_W{1'b0}};
            rd_ptr_q[i] <= {PTR_W{1'b0}};
            count_q[i]  <= {CNT_W{1'b0}};
         end
         rr_ptr_q     <= IDX_W'(NUM_PIPES - 1);
         wb_wr_en_q   <= 1'b0;
         wb_rd_q      <= {REG_WIDTH{1'b0}};
         wb_wr_data_q <= {DATA_WIDTH{1'b0}};
         wb_grant_q   <= {NUM_PIPES{1'b0}};
      end else begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
         rr_ptr_q     <= rr_ptr_d;
         wb_wr_en_q   <= wb_wr_en_d;
         wb_rd_q      <= wb_rd_d;
         wb_wr_data_q <= wb_wr_data_d;
         wb_grant_q   <= wb_grant_d;
      end
   end

   // FIFO storage; contents are only meaningful below the count, so no reset is needed
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (store_s[i]) begin
            rd_mem_q[i][wr_ptr_q[i]]   <= in_rd[i*REG_WIDTH +: REG_WIDTH];
            data_mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign in_ready   = ~full_s;
   assign busy       = (|(~empty_s)) | wb_wr_en_q;
   assign wb_wr_en   = wb_wr_en_q;
   assign wb_rd      = wb_rd_q;
   assign wb_wr_data = wb_wr_data_q;
   assign wb_grant   = wb_grant_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench for wb_commit_arbiter: one fixed-priority and one
// round-robin instance share the stimulus; each test checks the relevant one.
module tb_wb_commit_arbiter;

   logic         clk;
   logic         rst;
   logic [3:0]   in_valid;
   logic [3:0]   in_register_write;
   logic [19:0]  in_rd;
   logic [127:0] in_data;

   logic [3:0]   fp_in_ready, rr_in_ready;
   logic         fp_wb_wr_en, rr_wb_wr_en;
   logic [4:0]   fp_wb_rd, rr_wb_rd;
   logic [31:0]  fp_wb_wr_data, rr_wb_wr_data;
   logic [3:0]   fp_wb_grant, rr_wb_grant;
   logic         fp_busy, rr_busy;

   int checks;
   int errors;

   wb_commit_arbiter #(.NUM_PIPES(4), .DATA_WIDTH(32), .REG_WIDTH(5), .FIFO_DEPTH(2), .ARB_MODE(0)) dut_fp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fp_in_ready),
      .in_register_write(in_register_write), .in_rd(in_rd), .in_data(in_data),
      .wb_wr_en(fp_wb_wr_en), .wb_rd(fp_wb_rd), .wb_wr_data(fp_wb_wr_data),
      .wb_grant(fp_wb_grant), .busy(fp_busy)
   );

   wb_commit_arbiter #(.NUM_PIPES(4), .DATA_WIDTH(32), .REG_WIDTH(5), .FIFO_DEPTH(2), .ARB_MODE(1)) dut_rr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rr_in_ready),
      .in_register_write(in_register_write), .in_rd(in_rd), .in_data(in_data),
      .wb_wr_en(rr_wb_wr_en), .wb_rd(rr_wb_rd), .wb_wr_data(rr_wb_wr_data),
      .wb_grant(rr_wb_grant), .busy(rr_busy)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge; inputs change and outputs are sampled 1 unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pipe(input int p, input logic v, input logic rw,
                           input logic [4:0] rd, input logic [31:0] d);
      in_valid[p]          = v;
      in_register_write[p] = rw;
      in_rd[p*5 +: 5]      = rd;
      in_data[p*32 +: 32]  = d;
   endtask

   task automatic clear_inputs();
      in_valid          = 4'b0000;
      in_register_write = 4'b0000;
      in_rd             = 20'd0;
      in_data           = 128'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      clear_inputs();
      step();
      step();
      rst = 1'b0;

      // ---- reset while FIFOs hold data
      set_pipe(1, 1'b1, 1'b1, 5'd9,  32'h1111_0001);
      set_pipe(2, 1'b1, 1'b1, 5'd10, 32'h2222_0002);
      set_pipe(3, 1'b1, 1'b1, 5'd11, 32'h3333_0003);
      step();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_wr_en", fp_wb_wr_en, 64'd0);
      chk("rst_grant", fp_wb_grant, 64'd0);
      chk("rst_busy",  fp_busy,     64'd0);
      chk("rst_ready", fp_in_ready, 64'hF);
      chk("rst_rd",    fp_wb_rd,    64'd0);
      step();
      chk("rst_no_write", fp_wb_wr_en, 64'd0);

      // ---- single push from pipe 2
      set_pipe(2, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
      step();
      clear_inputs();
      step();
      chk("single_wr_en", fp_wb_wr_en,   64'd1);
      chk("single_rd",    fp_wb_rd,      64'd5);
      chk("single_data",  fp_wb_wr_data, 64'hDEADBEEF);
      chk("single_grant", fp_wb_grant,   64'h4);
      chk("single_busy",  fp_busy,       64'd1);
      step();
      chk("single_idle",  fp_wb_wr_en,   64'd0);
      chk("single_hold",  fp_wb_rd,      64'd5);
      chk("single_gnt0",  fp_wb_grant,   64'd0);

      // ---- fixed priority: all four pipes push together
      for (int p = 0; p < 4; p++) begin
         set_pipe(p, 1'b1, 1'b1, 5'(p + 1), 32'hA000_0000 + 32'(p));
      end
      step();
      clear_inputs();
      for (int p = 0; p < 4; p++) begin
         step();
         chk("fp_grant", fp_wb_grant,   64'(4'b0001 << p));
         chk("fp_rd",    fp_wb_rd,      64'(p + 1));
         chk("fp_data",  fp_wb_wr_data, 64'(32'hA000_0000 + 32'(p)));
      end
      step();
      chk("fp_drained", fp_wb_wr_en, 64'd0);

      // ---- full FIFO on pipe 1 while pipe 0 keeps priority
      set_pipe(0, 1'b1, 1'b1, 5'd10, 32'h0000_00C0);
      set_pipe(1, 1'b1, 1'b1, 5'd11, 32'hB000_0001);
      step();                                   // edge 1: both pushed
      chk("full_ready_e1", fp_in_ready[1], 64'd1);
      set_pipe(1, 1'b1, 1'b1, 5'd12, 32'hB000_0002);
      step();                                   // edge 2: pipe 1 now full
      chk("full_ready_e2", fp_in_ready[1], 64'd0);
      chk("full_grant_e2", fp_wb_grant,    64'h1);
      set_pipe(1, 1'b1, 1'b1, 5'd13, 32'hB000_0003);
      step();                                   // edge 3: third entry refused
      chk("full_ready_e3", fp_in_ready[1], 64'd0);
      chk("full_grant_e3", fp_wb_grant,    64'h1);
      set_pipe(0, 1'b0, 1'b0, 5'd0, 32'h0);
      step();                                   // edge 4: last pipe 0 entry leaves
      chk("full_grant_e4", fp_wb_grant,    64'h1);
      chk("full_ready_e4", fp_in_ready[1], 64'd0);
      step();                                   // edge 5: first pipe 1 pop, push still refused
      chk("full_grant_e5", fp_wb_grant,    64'h2);
      chk("full_rd_e5",    fp_wb_rd,       64'd11);
      chk("full_data_e5",  fp_wb_wr_data,  64'hB000_0001);
      chk("full_ready_e5", fp_in_ready[1], 64'd1);
      step();                                   // edge 6: third entry finally accepted
      clear_inputs();
      chk("full_rd_e6",    fp_wb_rd,       64'd12);
      chk("full_data_e6",  fp_wb_wr_data,  64'hB000_0002);
      step();
      chk("full_rd_e7",    fp_wb_rd,       64'd13);
      chk("full_data_e7",  fp_wb_wr_data,  64'hB000_0003);
      chk("full_grant_e7", fp_wb_grant,    64'h2);
      step();
      chk("full_drained",  fp_wb_wr_en,    64'd0);

      // ---- discard: rd = 0 on pipe 3, register_write = 0 on pipe 2
      set_pipe(3, 1'b1, 1'b1, 5'd0, 32'hFFFF_0003);
      set_pipe(2, 1'b1, 1'b0, 5'd7, 32'hFFFF_0002);
      chk("disc_ready", fp_in_ready, 64'hF);
      step();
      clear_inputs();
      chk("disc_busy",   fp_busy,     64'd0);
      chk("disc_wr_en",  fp_wb_wr_en, 64'd0);
      chk("disc_ready2", fp_in_ready, 64'hF);
      step();
      chk("disc_wr_en2", fp_wb_wr_en, 64'd0);
      chk("disc_busy2",  fp_busy,     64'd0);

      // ---- round-robin: pipes 0 and 3 push continuously
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_pipe(0, 1'b1, 1'b1, 5'd20, 32'h0000_0020);
      set_pipe(3, 1'b1, 1'b1, 5'd23, 32'h0000_0023);
      step();                                   // edge 1: both pushed, nothing granted yet
      chk("rr_idle", rr_wb_wr_en, 64'd0);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_grant", rr_wb_grant, (k % 2 == 0) ? 64'h1 : 64'h8);
         chk("rr_rd",    rr_wb_rd,    (k % 2 == 0) ? 64'd20 : 64'd23);
      end
      clear_inputs();
      for (int k = 0; k < 6; k++) begin
         step();
      end
      chk("rr_drained", rr_wb_wr_en, 64'd0);
      chk("rr_busy",    rr_busy,     64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
